adjust_controller: RTL
======================

# adjust_controller

Front-end control stage for the alarm clock. It conditions the raw push-buttons and decodes the 1 Hz tick into per-counter `enable`/`up`/`down` strobes for the time and alarm counter chain. It also sequences the run/adjust modes. It sits directly upstream of the seconds, minutes, hours, alarm-minutes and alarm-hours counters, and reads back their terminal-count flags to generate cascade carries.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable samples required to accept a button level (5 ms at 100 MHz).
- `CW`, default 19: width of the debounce counter; must satisfy 2^CW > DEBOUNCE_CYCLES.

Ports:
- `clk`, in, 1: system clock. The block has one clock; reset is asynchronous and active-low.
- `reset`, in, 1: asynchronous active-low reset (0 = asserted).
- `tick_1hz`, in, 1: single-cycle pulse once per second, already synchronous to `clk`.
- `btn_mode`, `btn_up`, `btn_down`, in, 1 each: raw asynchronous buttons, active-high.
- `sec_max`, `min_max`, in, 1 each: seconds counter is at 59; minutes counter is at 59.
- `sec_en`, `min_en`, `hour_en`, out, 1 each: enables for the time counters.
- `time_up`, `time_down`, out, 1 each: direction for the time counters.
- `amin_en`, `ahour_en`, out, 1 each: enables for the alarm counters.
- `alm_up`, `alm_down`, out, 1 each: direction for the alarm counters.
- `mode`, out, 3: current state code, used by the display for field blinking.

## Operation
- Each raw button passes through a 2-flop synchroniser and then a stability counter.
  - The debounced level changes only after `DEBOUNCE_CYCLES` consecutive equal samples that differ from the current level.
  - A debounced 0→1 transition produces a press pulse exactly one cycle wide.
- State codes: RUN=0, ADJ_T_HR=1, ADJ_T_MIN=2, ADJ_A_HR=3, ADJ_A_MIN=4. Codes 5–7 are illegal and return to RUN on the next cycle.
- A `mode` press advances RUN→ADJ_T_HR→ADJ_T_MIN→ADJ_A_HR→ADJ_A_MIN→RUN. No other input changes state.
- Time chain in RUN, ADJ_A_HR and ADJ_A_MIN (time keeps running while the alarm is adjusted):
  - `time_up`=1 and `time_down`=0.
  - `sec_en`=tick.
  - `min_en`=tick & `sec_max`.
  - `hour_en`=tick & `sec_max` & `min_max`.
- In ADJ_T_HR and ADJ_T_MIN, `tick_1hz` is ignored and time is frozen.
  - An up press drives the selected field's enable plus `time_up` for one cycle.
  - A down press drives the selected field's enable plus `time_down` for one cycle.
  - No carry is generated into the next field: adjusting minutes never touches hours.
- In ADJ_A_HR and ADJ_A_MIN, up and down presses drive `ahour_en` or `amin_en` together with `alm_up` or `alm_down` in the same way.
- In RUN, up and down presses are ignored. Alarm enables and alarm direction outputs are 0 outside the ADJ_A states.
- Simultaneous up and down presses in the same cycle: no strobe is issued.
- A mode press in the same cycle as an up or down press: the mode change wins and the up/down press is dropped.
- Enable and direction are never both asserted in opposite directions: `time_up`&`time_down`=0 and `alm_up`&`alm_down`=0 always.

## Timing
- All outputs are registered.
- Tick to `sec_en`: 1 cycle.
  - `sec_max` and `min_max` are sampled in the tick cycle.
  - The counters still hold their old values in that cycle, so the carry decode is correct.
- Raw button edge to press pulse: 2 (synchroniser) + `DEBOUNCE_CYCLES` + 1 cycles. Press pulse to counter strobe: 1 cycle.
- Press pulse to the `mode` output update: 1 cycle. A press in cycle k acts under the state as it was in cycle k.
- Every strobe is exactly 1 cycle wide. A held button yields one strobe; there is no auto-repeat.
- Reset, asynchronous, effective immediately:
  - State returns to RUN and `mode`=0.
  - All enables and directions go to 0.
  - Synchronisers, debounced levels and stability counters go to 0.
- A button held through reset release is treated as a new press once it has been stable for `DEBOUNCE_CYCLES`.

## Structure
- Shared package `alarm_clock_pkg`:
  - the state codes RUN…ADJ_A_MIN, mode width 3;
  - the default `DEBOUNCE_CYCLES`.
- Sub-module `btn_conditioner`: synchroniser, debounce counter and rising-edge pulse, parameterised by `DEBOUNCE_CYCLES` and `CW`. It is instantiated three times.
- The top level holds the FSM and the registered strobe/carry decode.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset: hold `reset`=0 with buttons toggling. Required: every output 0 and `mode`=0 throughout. Release with `btn_mode` held high → exactly one press is accepted, `mode`=1.
- Bounce: toggle `btn_up` every 2 cycles for 20 cycles, then hold high, in ADJ_T_MIN. Required: exactly one `min_en`+`time_up` pulse, arriving 2+4+1+1 cycles after the final rising edge.
- Carry: in RUN with `sec_max`=1, `min_max`=1, pulse `tick_1hz`. Required: `sec_en`, `min_en` and `hour_en` are all 1 for exactly one cycle, one cycle later. Repeat with `min_max`=0 → `hour_en` stays 0.
- Frozen time: in ADJ_T_HR, pulse tick 3 times. Required: no time enables. A down press → `hour_en`=1 and `time_down`=1 for one cycle.
- Alarm while running: in ADJ_A_MIN, a tick and an up press arrive in the same cycle. Required: `sec_en`, `time_up`, `amin_en` and `alm_up` all pulse together.
- Mode sequence: 5 mode presses from RUN. Required: `mode` goes 1, 2, 3, 4, 0. Up and down pressed together in ADJ_A_HR → no strobe.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared state codes and defaults for the alarm clock control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alarm_clock_pkg;

  localparam int MODE_W           = 3;
  localparam int DEBOUNCE_DEFAULT = 500000;

  typedef enum logic [MODE_W-1:0] {
    ST_RUN       = 3'd0,
    ST_ADJ_T_HR  = 3'd1,
    ST_ADJ_T_MIN = 3'd2,
    ST_ADJ_A_HR  = 3'd3,
    ST_ADJ_A_MIN = 3'd4
  } state_t;

endpackage

// File: rtl/btn_conditioner.sv
// Button front end: 2-flop synchroniser, stability-counter debounce, rising-edge pulse.
// Latency: raw edge to o_press = 2 + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none; o_press is a single-cycle strobe, a held button yields one pulse.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CW              = 19
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [CW-1:0] LP_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == LP_LAST) begin
      r_cnt   <= '0;
      r_level <= r_sync2;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered one-cycle pulse on a debounced 0->1 transition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/adjust_controller.sv
// Run/adjust mode FSM and registered enable/direction decode for the time and alarm counters.
// Latency: tick or press pulse to strobe 1 cycle; raw button to press pulse 2+DEBOUNCE_CYCLES+1.
// Backpressure: none; every strobe is one cycle, simultaneous up+down is dropped, mode beats up/down.
module adjust_controller
  import alarm_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CW              = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              sec_max,
  input  logic              min_max,
  output logic              sec_en,
  output logic              min_en,
  output logic              hour_en,
  output logic              time_up,
  output logic              time_down,
  output logic              amin_en,
  output logic              ahour_en,
  output logic              alm_up,
  output logic              alm_down,
  output logic [MODE_W-1:0] mode
);

  logic   w_mode_p;
  logic   w_up_p;
  logic   w_down_p;
  logic   w_adj_ok;

  state_t r_state;
  logic   r_sec_en, r_min_en, r_hour_en, r_time_up, r_time_down;
  logic   r_amin_en, r_ahour_en, r_alm_up, r_alm_down;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CW(CW)) u_btn_mode (
    .i_clk(clk), .i_rst_n(reset), .i_btn(btn_mode), .o_press(w_mode_p)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CW(CW)) u_btn_up (
    .i_clk(clk), .i_rst_n(reset), .i_btn(btn_up), .o_press(w_up_p)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CW(CW)) u_btn_down (
    .i_clk(clk), .i_rst_n(reset), .i_btn(btn_down), .o_press(w_down_p)
  );

  // Exactly one of up/down, and no mode press competing in the same cycle.
  assign w_adj_ok = (w_up_p ^ w_down_p) & ~w_mode_p;

  // Mode FSM plus strobe decode; outputs reflect the state as it was in the press/tick cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_sec_en    <= 1'b0;
      r_min_en    <= 1'b0;
      r_hour_en   <= 1'b0;
      r_time_up   <= 1'b0;
      r_time_down <= 1'b0;
      r_amin_en   <= 1'b0;
      r_ahour_en  <= 1'b0;
      r_alm_up    <= 1'b0;
      r_alm_down  <= 1'b0;
    end else begin
      r_sec_en    <= 1'b0;
      r_min_en    <= 1'b0;
      r_hour_en   <= 1'b0;
      r_time_up   <= 1'b0;
      r_time_down <= 1'b0;
      r_amin_en   <= 1'b0;
      r_ahour_en  <= 1'b0;
      r_alm_up    <= 1'b0;
      r_alm_down  <= 1'b0;

      case (r_state)
        ST_RUN, ST_ADJ_A_HR, ST_ADJ_A_MIN: begin
          // Time keeps running; carries use the counters' pre-increment flags.
          r_time_up <= 1'b1;
          r_sec_en  <= tick_1hz;
          r_min_en  <= tick_1hz & sec_max;
          r_hour_en <= tick_1hz & sec_max & min_max;
          if (r_state == ST_ADJ_A_HR) begin
            r_ahour_en <= w_adj_ok;
            r_alm_up   <= w_adj_ok & w_up_p;
            r_alm_down <= w_adj_ok & w_down_p;
          end else if (r_state == ST_ADJ_A_MIN) begin
            r_amin_en  <= w_adj_ok;
            r_alm_up   <= w_adj_ok & w_up_p;
            r_alm_down <= w_adj_ok & w_down_p;
          end
        end
        ST_ADJ_T_HR, ST_ADJ_T_MIN: begin
          // Time frozen: only manual strobes, no carry into the neighbouring field.
          r_hour_en   <= w_adj_ok & (r_state == ST_ADJ_T_HR);
          r_min_en    <= w_adj_ok & (r_state == ST_ADJ_T_MIN);
          r_time_up   <= w_adj_ok & w_up_p;
          r_time_down <= w_adj_ok & w_down_p;
        end
        default: ;
      endcase

      case (r_state)
        ST_RUN:       r_state <= w_mode_p ? ST_ADJ_T_HR  : ST_RUN;
        ST_ADJ_T_HR:  r_state <= w_mode_p ? ST_ADJ_T_MIN : ST_ADJ_T_HR;
        ST_ADJ_T_MIN: r_state <= w_mode_p ? ST_ADJ_A_HR  : ST_ADJ_T_MIN;
        ST_ADJ_A_HR:  r_state <= w_mode_p ? ST_ADJ_A_MIN : ST_ADJ_A_HR;
        ST_ADJ_A_MIN: r_state <= w_mode_p ? ST_RUN       : ST_ADJ_A_MIN;
        default:      r_state <= ST_RUN;
      endcase
    end
  end

  assign sec_en    = r_sec_en;
  assign min_en    = r_min_en;
  assign hour_en   = r_hour_en;
  assign time_up   = r_time_up;
  assign time_down = r_time_down;
  assign amin_en   = r_amin_en;
  assign ahour_en  = r_ahour_en;
  assign alm_up    = r_alm_up;
  assign alm_down  = r_alm_down;
  assign mode      = r_state;

endmodule
